// File: rtl/sequenciador_if.sv
// Program-memory and status bus of the sequenciador.
// The master drives run and dado; the slave (the core) drives the rest.
interface sequenciador_if;
  logic       run;
  logic [7:0] dado;
  logic [4:0] endereco;
  logic [7:0] saida;
  logic       ocupado;
  logic       acabou;

  modport master (
    output run, dado,
    input  endereco, saida, ocupado, acabou
  );

  modport slave (
    input  run, dado,
    output endereco, saida, ocupado, acabou
  );
endinterface

// File: rtl/sequenciador.sv
// Tiny accumulator sequencer: fetch/execute FSM over a 32-word program memory.
// Define SEQ_SUBROTINA_EN to enable single-level CALL (0110) / RET (0111).
module sequenciador (
  input logic           clk,
  input logic           reset,
  sequenciador_if.slave bus
);

  typedef enum logic [2:0] {
    PARADO,
    BUSCA,
    EXECUTA,
    ESPERA,
    FIM
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] saida_q, saida_d;
  logic       ocupado_q, ocupado_d;
  logic       acabou_q, acabou_d;
`ifdef SEQ_SUBROTINA_EN
  logic [4:0] ret_q, ret_d;
`endif

  logic [3:0] opcode;
  logic [3:0] operando;

  assign opcode   = ir_q[7:4];
  assign operando = ir_q[3:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    saida_d = saida_q;
`ifdef SEQ_SUBROTINA_EN
    ret_d   = ret_q;
`endif
    unique case (state_q)
      PARADO, FIM: begin
        if (bus.run) begin
          state_d = BUSCA;
          pc_d    = 5'd0;
          acc_d   = 8'd0;
        end
      end
      BUSCA: begin
        ir_d    = bus.dado;
        pc_d    = pc_q + 5'd1;
        state_d = EXECUTA;
      end
      EXECUTA: begin
        state_d = BUSCA;
        case (opcode)
          4'h0: acc_d = {4'h0, operando};
          4'h1: acc_d = acc_q + {4'h0, operando};
          4'h2: acc_d = acc_q - {4'h0, operando};
          4'h3: saida_d = acc_q;
          4'h4: pc_d = {1'b0, operando};
          4'h5: if (acc_q == 8'd0) pc_d = {1'b0, operando};
`ifdef SEQ_SUBROTINA_EN
          4'h6: begin
            ret_d = pc_q;
            pc_d  = {1'b0, operando};
          end
          4'h7: pc_d = ret_q;
`endif
          4'hA: begin
            if (operando != 4'd0) begin
              cnt_d   = operando;
              state_d = ESPERA;
            end
          end
          4'hF: state_d = FIM;
          default: ;
        endcase
      end
      ESPERA: begin
        cnt_d = cnt_q - 4'd1;
        // a counter of 1 is the last extra cycle
        if (cnt_q <= 4'd1) state_d = BUSCA;
      end
      default: state_d = PARADO;
    endcase
    ocupado_d = (state_d == BUSCA) || (state_d == EXECUTA) ||
                (state_d == ESPERA);
    acabou_d  = (state_d == FIM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PARADO;
      pc_q      <= 5'd0;
      ir_q      <= 8'd0;
      acc_q     <= 8'd0;
      cnt_q     <= 4'd0;
      saida_q   <= 8'd0;
      ocupado_q <= 1'b0;
      acabou_q  <= 1'b0;
`ifdef SEQ_SUBROTINA_EN
      ret_q     <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      ocupado_q <= ocupado_d;
      acabou_q  <= acabou_d;
`ifdef SEQ_SUBROTINA_EN
      ret_q     <= ret_d;
`endif
    end
  end

  assign bus.endereco = pc_q;
  assign bus.saida    = saida_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.acabou   = acabou_q;

endmodule
